cache_nway_wb: RTL and testbench



---
 rtl/lc3b_types.sv | 10 +
 rtl/cache_nway_wb_plru_tree.sv | 26 ++
 rtl/cache_nway_wb.sv | 168 ++++++++++++++++
 tb/tb_cache_nway_wb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared lc3b memory-system types: address/line widths and the cache controller states.
package lc3b_types;
   localparam int LINE_OFFSET_BITS = 4;
   localparam int ADDR_WIDTH       = 16;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} cache_state_e;
endpackage

// File: rtl/cache_nway_wb_plru_tree.sv
// Tree pseudo-LRU: victim walk and post-access update for one set's WAYS-1 tree bits.
// Node n (heap order, root = 1) lives in bit n-1; a 0 bit points at the lower half.
module plru_tree #(
   parameter int WAYS = 2
) (
   input  logic [WAYS-2:0]         tree,
   input  logic [$clog2(WAYS)-1:0] access_way,
   output logic [$clog2(WAYS)-1:0] victim,
   output logic [WAYS-2:0]         next_tree
);
   localparam int LEVELS = $clog2(WAYS);

   always_comb begin
      int node;
      node = 1;
      for (int l = 0; l < LEVELS; l++) node = 2 * node + int'(tree[node-1]);
      victim = LEVELS'(node - WAYS);

      next_tree = tree;
      node      = 1;
      for (int l = 0; l < LEVELS; l++) begin
         next_tree[node-1] = ~access_way[LEVELS-1-l];
         node = 2 * node + int'(access_way[LEVELS-1-l]);
      end
   end
endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back / write-allocate cache with tree PLRU and
// saturating hit/miss/writeback counters.
module cache_nway_wb
   import lc3b_types::*;
#(
   parameter int WAYS      = 2,
   parameter int SET_BITS  = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cache_read,
   input  logic                 cache_write,
   input  logic [15:0]          cache_address,
   input  logic [15:0]          cache_wdata,
   input  logic [1:0]           cache_byte_enable,
   output logic [15:0]          cache_rdata,
   output logic                 cache_resp,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [15:0]          mem_address,
   output logic [127:0]         mem_wdata,
   input  logic [127:0]         mem_rdata,
   input  logic                 mem_resp,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);
   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = ADDR_WIDTH - LINE_OFFSET_BITS - SET_BITS;
   localparam int WB    = $clog2(WAYS);

   cache_state_e state, state_n;

   logic [TAG_W-1:0] tags [WAYS][SETS];
   lc3b_line         data [WAYS][SETS];
   logic [SETS-1:0][WAYS-1:0] valid, dirty;
   logic [SETS-1:0][WAYS-2:0] plru;

   logic [SET_BITS-1:0] idx;
   logic [TAG_W-1:0]    tag;
   logic [2:0]          word_sel;
   logic                unused;
   assign idx      = cache_address[LINE_OFFSET_BITS +: SET_BITS];
   assign tag      = cache_address[ADDR_WIDTH-1 -: TAG_W];
   assign word_sel = cache_address[3:1];
   assign unused   = cache_address[0];

   logic          hit, any_inv, replay;
   logic [WB-1:0] hit_way, inv_way, plru_way, victim_sel, victim_q;
   logic [WAYS-2:0] plru_next;
   lc3b_line      sel_line;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      any_inv = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[idx][w] && tags[w][idx] == tag) begin
            hit     = 1'b1;
            hit_way = WB'(w);
         end
         if (!valid[idx][w]) begin
            any_inv = 1'b1;
            inv_way = WB'(w);
         end
      end
   end

   plru_tree #(.WAYS(WAYS)) u_plru (
      .tree      (plru[idx]),
      .access_way(hit_way),
      .victim    (plru_way),
      .next_tree (plru_next)
   );

   assign victim_sel = any_inv ? inv_way : plru_way;
   assign sel_line   = data[hit_way][idx];

   always_comb begin
      state_n     = state;
      cache_resp  = 1'b0;
      cache_rdata = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      case (state)
         IDLE: if (cache_read || cache_write) state_n = LOOKUP;
         LOOKUP: begin
            if (hit) begin
               cache_resp  = 1'b1;
               cache_rdata = sel_line[{word_sel, 4'h0} +: 16];
               state_n     = IDLE;
            end else if (valid[idx][victim_sel] && dirty[idx][victim_sel]) begin
               state_n = WRITEBACK;
            end else begin
               state_n = FILL;
            end
         end
         WRITEBACK: begin
            mem_write   = 1'b1;
            mem_address = {tags[victim_q][idx], idx, 4'h0};
            mem_wdata   = data[victim_q][idx];
            if (mem_resp) state_n = FILL;
         end
         FILL: begin
            mem_read    = 1'b1;
            mem_address = {cache_address[15:4], 4'h0};
            if (mem_resp) state_n = LOOKUP;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         valid      <= '0;
         dirty      <= '0;
         plru       <= '0;
         victim_q   <= '0;
         replay     <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         state <= state_n;
         case (state)
            LOOKUP: begin
               if (hit) begin
                  plru[idx] <= plru_next;
                  replay    <= 1'b0;
                  if (cache_write) dirty[idx][hit_way] <= 1'b1;
                  // the replay after a fill is a guaranteed hit and is not counted
                  if (!replay && !(&hit_count)) hit_count <= hit_count + CNT_WIDTH'(1);
               end else begin
                  victim_q <= victim_sel;
                  if (!(&miss_count)) miss_count <= miss_count + CNT_WIDTH'(1);
               end
            end
            WRITEBACK: if (mem_resp) begin
               dirty[idx][victim_q] <= 1'b0;
               if (!(&wb_count)) wb_count <= wb_count + CNT_WIDTH'(1);
            end
            FILL: if (mem_resp) begin
               valid[idx][victim_q] <= 1'b1;
               dirty[idx][victim_q] <= 1'b0;
               replay               <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid bits qualify them.
   always_ff @(posedge clk) begin
      if (state == LOOKUP && hit && cache_write) begin
         if (cache_byte_enable[0]) data[hit_way][idx][{word_sel, 4'h0} +: 8] <= cache_wdata[7:0];
         if (cache_byte_enable[1]) data[hit_way][idx][{word_sel, 4'h8} +: 8] <= cache_wdata[15:8];
      end
      if (state == FILL && mem_resp) begin
         data[victim_q][idx] <= mem_rdata;
         tags[victim_q][idx] <= tag;
      end
   end
endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb: a 2-way/16-set and a 4-way/4-set instance
// behind one muxed stimulus port, with a fixed-latency memory responder.
module tb_cache_nway_wb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         sel = 1'b0;
   logic         read = 1'b0, write = 1'b0, mem_resp = 1'b0;
   logic [15:0]  addr = '0, wdata = '0;
   logic [1:0]   ben = '0;
   logic [127:0] mem_rdata = '0;

   logic [15:0]  rd0, rd1, ma0, ma1;
   logic         rsp0, rsp1, mr0, mr1, mw0, mw1;
   logic [127:0] wd0, wd1;
   logic [15:0]  hc0, hc1, mc0, mc1, wc0, wc1;

   cache_nway_wb dut2 (
      .clk(clk), .rst(rst),
      .cache_read(read & ~sel), .cache_write(write & ~sel),
      .cache_address(addr), .cache_wdata(wdata), .cache_byte_enable(ben),
      .cache_rdata(rd0), .cache_resp(rsp0),
      .mem_read(mr0), .mem_write(mw0), .mem_address(ma0), .mem_wdata(wd0),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp & ~sel),
      .hit_count(hc0), .miss_count(mc0), .wb_count(wc0)
   );

   cache_nway_wb #(.WAYS(4), .SET_BITS(2), .CNT_WIDTH(16)) dut4 (
      .clk(clk), .rst(rst),
      .cache_read(read & sel), .cache_write(write & sel),
      .cache_address(addr), .cache_wdata(wdata), .cache_byte_enable(ben),
      .cache_rdata(rd1), .cache_resp(rsp1),
      .mem_read(mr1), .mem_write(mw1), .mem_address(ma1), .mem_wdata(wd1),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp & sel),
      .hit_count(hc1), .miss_count(mc1), .wb_count(wc1)
   );

   wire [15:0]  o_rdata = sel ? rd1 : rd0;
   wire         o_resp  = sel ? rsp1 : rsp0;
   wire         o_mrd   = sel ? mr1 : mr0;
   wire         o_mwr   = sel ? mw1 : mw0;
   wire [15:0]  o_maddr = sel ? ma1 : ma0;
   wire [127:0] o_mwd   = sel ? wd1 : wd0;
   wire [15:0]  o_hit   = sel ? hc1 : hc0;
   wire [15:0]  o_miss  = sel ? mc1 : mc0;
   wire [15:0]  o_wb    = sel ? wc1 : wc0;

   int nvec = 0, nbad = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] dline(input logic [15:0] a);
      logic [127:0] l;
      for (int w = 0; w < 8; w++) l[w*16 +: 16] = {a[15:4], 1'b0, 3'(w)};
      return l;
   endfunction

   function automatic logic [127:0] setw(input logic [127:0] l, input int w, input logic [15:0] v);
      logic [127:0] r;
      r = l;
      r[w*16 +: 16] = v;
      return r;
   endfunction

   // memory model: responds on the third falling edge a request is seen
   localparam int MEM_LAT = 2;
   logic [127:0] model [logic [15:0]];
   int           mwait = 0, nfills = 0, nwbs = 0;
   logic [15:0]  last_fill_addr = '0, last_wb_addr = '0;
   logic [127:0] last_wb_line = '0;

   initial forever begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (o_mrd || o_mwr) begin
         if (mwait == MEM_LAT) begin
            mem_resp = 1'b1;
            mwait    = 0;
            if (o_mwr) begin
               model[o_maddr] = o_mwd;
               last_wb_addr   = o_maddr;
               last_wb_line   = o_mwd;
               nwbs++;
            end else begin
               mem_rdata      = model.exists(o_maddr) ? model[o_maddr] : dline(o_maddr);
               last_fill_addr = o_maddr;
               nfills++;
            end
         end else mwait++;
      end else mwait = 0;
   end

   task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         input logic [1:0] be, output logic [15:0] rdat, output int cyc,
                         output logic got);
      @(negedge clk);
      addr = a; wdata = wd; ben = be; read = ~wr; write = wr;
      cyc = 1; got = 1'b0; rdat = '0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (o_resp) begin
            got  = 1'b1;
            rdat = o_rdata;
         end
      end
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0;
   endtask

   typedef struct {
      logic         d, wr;
      logic [15:0]  a, wd;
      logic [1:0]   be;
      logic [15:0]  rd;
      int           cyc, nf, nw;
      logic [15:0]  fa, wa;
      logic [127:0] wl;
      int           h, m, wb;
   } vec_t;

   function automatic vec_t mk(input logic d, input logic wr, input logic [15:0] a,
                               input logic [15:0] wd, input logic [1:0] be, input logic [15:0] rd,
                               input int cyc, input int nf, input int nw, input logic [15:0] fa,
                               input logic [15:0] wa, input logic [127:0] wl,
                               input int h, input int m, input int wb);
      vec_t v;
      v.d = d; v.wr = wr; v.a = a; v.wd = wd; v.be = be; v.rd = rd;
      v.cyc = cyc; v.nf = nf; v.nw = nw; v.fa = fa; v.wa = wa; v.wl = wl;
      v.h = h; v.m = m; v.wb = wb;
      return v;
   endfunction

   vec_t vecs [24];

   initial begin
      logic [127:0] l12, l22;
      logic [15:0]  rdat;
      int           cyc, f0, w0;
      logic         got;

      l12 = setw(setw(dline(16'h1230), 2, 16'hBEEF), 3, 16'h12C3);
      l22 = setw(dline(16'h2230), 1, 16'h1111);
      model[16'h1230] = setw(dline(16'h1230), 2, 16'hBEEF);

      //            d  wr  addr      wdata     be     rdata     cyc nf nw fill      wb addr   wb line h  m  wb
      vecs[0]  = mk(0, 0, 16'h1234, 16'h0000, 2'b00, 16'hBEEF, 6, 1, 0, 16'h1230, 16'h0000, '0,  0, 1, 0);
      vecs[1]  = mk(0, 0, 16'h1234, 16'h0000, 2'b00, 16'hBEEF, 2, 0, 0, 16'h0000, 16'h0000, '0,  1, 1, 0);
      vecs[2]  = mk(0, 1, 16'h1236, 16'hA5C3, 2'b01, 16'h0000, 2, 0, 0, 16'h0000, 16'h0000, '0,  2, 1, 0);
      vecs[3]  = mk(0, 0, 16'h1236, 16'h0000, 2'b00, 16'h12C3, 2, 0, 0, 16'h0000, 16'h0000, '0,  3, 1, 0);
      vecs[4]  = mk(0, 0, 16'h2230, 16'h0000, 2'b00, 16'h2230, 6, 1, 0, 16'h2230, 16'h0000, '0,  3, 2, 0);
      vecs[5]  = mk(0, 1, 16'h2232, 16'h1111, 2'b11, 16'h0000, 2, 0, 0, 16'h0000, 16'h0000, '0,  4, 2, 0);
      vecs[6]  = mk(0, 0, 16'h1230, 16'h0000, 2'b00, 16'h1230, 2, 0, 0, 16'h0000, 16'h0000, '0,  5, 2, 0);
      vecs[7]  = mk(0, 0, 16'h3230, 16'h0000, 2'b00, 16'h3230, 9, 1, 1, 16'h3230, 16'h2230, l22, 5, 3, 1);
      vecs[8]  = mk(0, 0, 16'h2232, 16'h0000, 2'b00, 16'h1111, 9, 1, 1, 16'h2230, 16'h1230, l12, 5, 4, 2);
      vecs[9]  = mk(0, 0, 16'h1236, 16'h0000, 2'b00, 16'h12C3, 6, 1, 0, 16'h1230, 16'h0000, '0,  5, 5, 2);
      vecs[10] = mk(0, 1, 16'h1234, 16'hFFFF, 2'b00, 16'h0000, 2, 0, 0, 16'h0000, 16'h0000, '0,  6, 5, 2);
      vecs[11] = mk(0, 0, 16'h1234, 16'h0000, 2'b00, 16'hBEEF, 2, 0, 0, 16'h0000, 16'h0000, '0,  7, 5, 2);
      vecs[12] = mk(0, 0, 16'h4230, 16'h0000, 2'b00, 16'h4230, 6, 1, 0, 16'h4230, 16'h0000, '0,  7, 6, 2);
      vecs[13] = mk(0, 0, 16'h5230, 16'h0000, 2'b00, 16'h5230, 9, 1, 1, 16'h5230, 16'h1230, l12, 7, 7, 3);
      vecs[14] = mk(1, 0, 16'h0100, 16'h0000, 2'b00, 16'h0100, 6, 1, 0, 16'h0100, 16'h0000, '0,  0, 1, 0);
      vecs[15] = mk(1, 0, 16'h0200, 16'h0000, 2'b00, 16'h0200, 6, 1, 0, 16'h0200, 16'h0000, '0,  0, 2, 0);
      vecs[16] = mk(1, 0, 16'h0300, 16'h0000, 2'b00, 16'h0300, 6, 1, 0, 16'h0300, 16'h0000, '0,  0, 3, 0);
      vecs[17] = mk(1, 0, 16'h0400, 16'h0000, 2'b00, 16'h0400, 6, 1, 0, 16'h0400, 16'h0000, '0,  0, 4, 0);
      vecs[18] = mk(1, 0, 16'h0500, 16'h0000, 2'b00, 16'h0500, 6, 1, 0, 16'h0500, 16'h0000, '0,  0, 5, 0);
      vecs[19] = mk(1, 0, 16'h0200, 16'h0000, 2'b00, 16'h0200, 2, 0, 0, 16'h0000, 16'h0000, '0,  1, 5, 0);
      vecs[20] = mk(1, 0, 16'h0300, 16'h0000, 2'b00, 16'h0300, 2, 0, 0, 16'h0000, 16'h0000, '0,  2, 5, 0);
      vecs[21] = mk(1, 0, 16'h0400, 16'h0000, 2'b00, 16'h0400, 2, 0, 0, 16'h0000, 16'h0000, '0,  3, 5, 0);
      vecs[22] = mk(1, 0, 16'h0500, 16'h0000, 2'b00, 16'h0500, 2, 0, 0, 16'h0000, 16'h0000, '0,  4, 5, 0);
      vecs[23] = mk(1, 0, 16'h0100, 16'h0000, 2'b00, 16'h0100, 6, 1, 0, 16'h0100, 16'h0000, '0,  4, 6, 0);

      // reset state
      repeat (2) @(negedge clk);
      chk("rst cache_resp", 128'(rsp0), 128'(0));
      chk("rst mem_read", 128'(mr0), 128'(0));
      chk("rst mem_write", 128'(mw0), 128'(0));
      chk("rst cache_rdata", 128'(rd0), 128'(0));
      chk("rst mem_address", 128'(ma0), 128'(0));
      chk("rst mem_wdata", wd0, 128'(0));
      chk("rst counters", 128'({hc0, mc0, wc0}), 128'(0));
      chk("rst mem_read w4", 128'(mr1), 128'(0));
      rst = 1'b0;

      foreach (vecs[i]) begin
         sel = vecs[i].d;
         f0  = nfills;
         w0  = nwbs;
         access(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].be, rdat, cyc, got);
         chk($sformatf("v%0d resp seen", i), 128'(got), 128'(1));
         chk($sformatf("v%0d cycles", i), 128'(cyc), 128'(vecs[i].cyc));
         if (!vecs[i].wr) chk($sformatf("v%0d rdata", i), 128'(rdat), 128'(vecs[i].rd));
         chk($sformatf("v%0d fills", i), 128'(nfills - f0), 128'(vecs[i].nf));
         chk($sformatf("v%0d writebacks", i), 128'(nwbs - w0), 128'(vecs[i].nw));
         if (vecs[i].nf > 0) chk($sformatf("v%0d fill addr", i), 128'(last_fill_addr), 128'(vecs[i].fa));
         if (vecs[i].nw > 0) begin
            chk($sformatf("v%0d wb addr", i), 128'(last_wb_addr), 128'(vecs[i].wa));
            chk($sformatf("v%0d wb line", i), last_wb_line, vecs[i].wl);
         end
         chk($sformatf("v%0d hit_count", i), 128'(o_hit), 128'(vecs[i].h));
         chk($sformatf("v%0d miss_count", i), 128'(o_miss), 128'(vecs[i].m));
         chk($sformatf("v%0d wb_count", i), 128'(o_wb), 128'(vecs[i].wb));
      end

      // asynchronous reset in the middle of a fill
      sel = 1'b0;
      @(negedge clk);
      addr = 16'h6230; read = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(posedge clk); #1;
         if (o_mrd) got = 1'b1;
      end
      chk("midfill mem_read seen", 128'(got), 128'(1));
      rst = 1'b1;
      #1;
      chk("midfill mem_read drop", 128'(o_mrd), 128'(0));
      chk("midfill mem_write", 128'(o_mwr), 128'(0));
      chk("midfill counters", 128'({o_hit, o_miss, o_wb}), 128'(0));
      read = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      f0 = nfills;
      access(1'b0, 16'h6230, 16'h0, 2'b00, rdat, cyc, got);
      chk("refill resp seen", 128'(got), 128'(1));
      chk("refill cycles", 128'(cyc), 128'(6));
      chk("refill fills", 128'(nfills - f0), 128'(1));
      chk("refill rdata", 128'(rdat), 128'(16'h6230));
      chk("refill miss_count", 128'(o_miss), 128'(1));
      chk("refill hit_count", 128'(o_hit), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
